// File: rtl/alu_core.sv
// alu_core: two-operand integer ALU (add, sub, AND, NOT B) with registered result and Z/N/V flags.
// Latency: one cycle from an accepted request (in_valid high at clk edge) to out/flags/out_valid.
// Backpressure: none; a request is accepted every cycle in_valid is high, and results are never stalled.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid           request strobe; Ain/Bin/ALUop captured when high at a clk edge
//   Ain, Bin, ALUop    operands (two's complement) and operation select
//   out, Z, N, V       registered result and zero/negative/signed-overflow flags
//   out_valid          high for exactly the cycle after an accepted request
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  alu_op_e          op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] res;
  logic             res_v;

  logic [WIDTH-1:0] out_d, out_q;
  logic             z_d, z_q;
  logic             n_d, n_q;
  logic             v_d, v_q;
  logic             out_valid_d, out_valid_q;

  assign op     = alu_op_e'(ALUop);
  assign is_sub = (op == OP_SUB);

  // Add and subtract share one adder: subtract is A + ~B + 1, with the +1 as carry-in.
  assign b_eff = is_sub ? ~Bin : Bin;
  assign sum   = Ain + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

  // Overflow when both adder inputs share a sign and the sum's sign differs. With B
  // inverted for subtract this is exactly "A and B differ in sign and result differs from A".
  assign sum_ovf = (Ain[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);

  always_comb begin
    res   = sum;
    res_v = 1'b0;
    unique case (op)
      OP_ADD,
      OP_SUB: begin
        res   = sum;
        res_v = sum_ovf;
      end
      OP_AND: res = Ain & Bin;
      OP_NOT: res = ~Bin;
      default: begin
        res   = sum;
        res_v = 1'b0;
      end
    endcase
  end

  // Result and flags hold when idle; they always update together from one request.
  always_comb begin
    out_d       = out_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = res;
      z_d   = (res == '0);
      n_d   = res[WIDTH-1];
      v_d   = res_v;
    end
  end

  // Reset wins over a simultaneous request, so that request is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed table-driven bench for alu_core (WIDTH=16).
// Latency: each vector is driven, one clk edge elapses, then outputs are compared.
// Backpressure: not applicable; vectors are applied one per cycle.
module tb_alu_core;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] out;
  logic             Z;
  logic             N;
  logic             V;
  logic             out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .out       (out),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst;
    logic             vld;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] e_out;
    logic             e_z;
    logic             e_n;
    logic             e_v;
    logic             e_ov;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic rst, input logic vld,
                         input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e_out,
                         input logic e_z, input logic e_n, input logic e_v,
                         input logic e_ov);
    vec_t v;
    v.name = name; v.rst = rst; v.vld = vld; v.op = op; v.a = a; v.b = b;
    v.e_out = e_out; v.e_z = e_z; v.e_n = e_n; v.e_v = e_v; v.e_ov = e_ov;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input string field,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [WIDTH-1:0] e_out,
                           input logic e_z, input logic e_n, input logic e_v,
                           input logic e_ov);
    check(name, "out",       out,                     e_out);
    check(name, "Z",         {{(WIDTH-1){1'b0}}, Z},         {{(WIDTH-1){1'b0}}, e_z});
    check(name, "N",         {{(WIDTH-1){1'b0}}, N},         {{(WIDTH-1){1'b0}}, e_n});
    check(name, "V",         {{(WIDTH-1){1'b0}}, V},         {{(WIDTH-1){1'b0}}, e_v});
    check(name, "out_valid", {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, e_ov});
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic rst, input logic vld, input logic [1:0] op,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    reset = rst; in_valid = vld; ALUop = op; Ain = a; Bin = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ALUop = 2'b00; Ain = '0; Bin = '0;

    //        name         rst  vld  op     A        B        out      Z  N  V  ov
    add_vec("rst0",       1, 1, 2'b00, 16'h0001, 16'h0003, 16'h0000, 0, 0, 0, 0);
    add_vec("rst1",       1, 1, 2'b00, 16'h0001, 16'h0003, 16'h0000, 0, 0, 0, 0);
    add_vec("rel_1p3",    0, 1, 2'b00, 16'h0001, 16'h0003, 16'h0004, 0, 0, 0, 1);
    add_vec("add_0p0",    0, 1, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1);
    add_vec("add_1p3",    0, 1, 2'b00, 16'h0001, 16'h0003, 16'h0004, 0, 0, 0, 1);
    add_vec("add_max",    0, 1, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1, 1);
    add_vec("idle_hold1", 0, 0, 2'b00, 16'hFFFF, 16'h0001, 16'h8000, 0, 1, 1, 0);
    add_vec("add_negneg", 0, 1, 2'b00, 16'h8000, 16'h8000, 16'h0000, 1, 0, 1, 1);
    add_vec("add_mixed",  0, 1, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 1);
    add_vec("sub_100m24", 0, 1, 2'b01, 16'd100,  16'd24,   16'd76,   0, 0, 0, 1);
    add_vec("sub_0m0",    0, 1, 2'b01, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1);
    add_vec("sub_0m1",    0, 1, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 0, 1);
    add_vec("sub_min",    0, 1, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 1);
    add_vec("sub_maxmn1", 0, 1, 2'b01, 16'h7FFF, 16'hFFFF, 16'h8000, 0, 1, 1, 1);
    add_vec("and_zero",   0, 1, 2'b10, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1);
    add_vec("and_mix",    0, 1, 2'b10, 16'h6F02, 16'hA6CB, 16'h2602, 0, 0, 0, 1);
    add_vec("and_neg",    0, 1, 2'b10, 16'hFFFF, 16'h8001, 16'h8001, 0, 1, 0, 1);
    add_vec("not_0",      0, 1, 2'b11, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 1);
    add_vec("not_8e38",   0, 1, 2'b11, 16'h0000, 16'h8E38, 16'h71C7, 0, 0, 0, 1);
    add_vec("not_ign_a",  0, 1, 2'b11, 16'h8C08, 16'h8E38, 16'h71C7, 0, 0, 0, 1);
    add_vec("not_ffff",   0, 1, 2'b11, 16'h1234, 16'hFFFF, 16'h0000, 1, 0, 0, 1);
    add_vec("b2b_1p3",    0, 1, 2'b00, 16'h0001, 16'h0003, 16'h0004, 0, 0, 0, 1);
    add_vec("b2b_100m24", 0, 1, 2'b01, 16'd100,  16'd24,   16'd76,   0, 0, 0, 1);
    add_vec("idle_hold2", 0, 0, 2'b00, 16'hFFFF, 16'h0001, 16'd76,   0, 0, 0, 0);
    add_vec("idle_hold3", 0, 0, 2'b11, 16'h0000, 16'h0000, 16'd76,   0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].a, vecs[i].b);
      check_all(vecs[i].name, vecs[i].e_out, vecs[i].e_z, vecs[i].e_n,
                vecs[i].e_v, vecs[i].e_ov);
    end

    // Reset from a non-zero state clears every register, and a request presented
    // together with reset is discarded rather than emerging a cycle later.
    step(0, 1, 2'b00, 16'h7FFF, 16'h0001);
    check_all("pre_rst", 16'h8000, 0, 1, 1, 1);
    step(1, 1, 2'b00, 16'h0005, 16'h0005);
    check_all("rst_drop", 16'h0000, 0, 0, 0, 0);
    step(0, 0, 2'b00, 16'h0005, 16'h0005);
    check_all("after_drop", 16'h0000, 0, 0, 0, 0);

    // out_valid is a single-cycle pulse for an isolated request.
    step(0, 1, 2'b01, 16'h0000, 16'h0001);
    check_all("pulse_on", 16'hFFFF, 0, 1, 0, 1);
    step(0, 0, 2'b10, 16'h0000, 16'h0000);
    check_all("pulse_off", 16'hFFFF, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Two-operand integer ALU for the datapath: add, subtract, bitwise AND, bitwise NOT of B.
- Result and status flags are registered, one cycle after an accepted request.
- Sits between the register-file operand latches (A/B) and the writeback/status registers.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement); minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe; operands and op are captured when high at a clk edge.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- ALUop  input  2  operation select.
- out  output  WIDTH  registered result.
- Z  output  1  registered zero flag: out == 0.
- N  output  1  registered negative flag: out[WIDTH-1].
- V  output  1  registered signed-overflow flag.
- out_valid  output  1  high for exactly the cycle after an accepted request.

Behaviour:
- Reset (reset=1 at clk edge, priority over in_valid): out=0, Z=0, N=0, V=0, out_valid=0.
- A reset asserted while a request is being accepted discards that request; nothing is produced for it.
- Latency is 1 cycle. A request accepted at edge k appears on out, flags and out_valid after edge k.
- Throughput is one request per cycle. Back-to-back requests produce back-to-back results, with out_valid staying high.
- If in_valid=0 at an edge: out, Z, N and V hold their previous values, and out_valid=0.
- ALUop=00: out = (Ain + Bin) mod 2^WIDTH. Carry is discarded.
- ALUop=01: out = (Ain - Bin) mod 2^WIDTH, computed as Ain + ~Bin + 1.
- ALUop=10: out = Ain & Bin, bitwise.
- ALUop=11: out = ~Bin, bitwise. Ain is ignored.
- Z = 1 when the new out is all zeros, for every op.
- N = MSB of the new out, for every op.
- V for add: 1 when Ain and Bin have the same sign and the result sign differs.
- V for sub: 1 when Ain and Bin have different signs and the result sign differs from Ain.
- V for AND and NOT: always 0.
- Wrap-around is mandatory, with no saturation:
  - 0x7FFF+1 -> 0x8000, V=1.
  - 0x8000-1 -> 0x7FFF, V=1.
  - 0-1 -> 0xFFFF, V=0.
- Flags and out always update together from the same captured request.
- There are no other states. The block has no internal state besides the output registers.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 and ALUop=00, Ain=1, Bin=3 -> out=0, Z=N=V=0, out_valid=0 throughout. Release reset -> next edge gives out=4, out_valid=1.
- Add, ALUop=00:
  - 0+0 -> out=0, Z=1.
  - 1+3 -> out=4, Z=0.
  - 0x7FFF+1 -> out=0x8000, N=1, V=1.
  - Each result is present one cycle after its request.
- Sub, ALUop=01:
  - 100-24 -> out=76.
  - 0-0 -> out=0, Z=1.
  - 0-1 -> out=0xFFFF, N=1, V=0.
  - 0x8000-1 -> out=0x7FFF, N=0, V=1.
- AND, ALUop=10:
  - 0x0000&0x0000 -> out=0, Z=1.
  - 0x6F02&0xA6CB -> out=0x2602, V=0.
- NOT, ALUop=11:
  - Bin=0 -> out=0xFFFF, N=1.
  - Bin=0x8E38 -> out=0x71C7.
  - Ain=0x8C08, Bin=0x8E38 -> out=0x71C7, so Ain has no effect.
- Handshake:
  - Back-to-back requests 1+3 then 100-24 -> out=4 then 76 on consecutive cycles, out_valid high both cycles.
  - Then drop in_valid -> out holds 76, Z/N/V hold, out_valid=0.
